// File: rtl/axi4_stream_src_pkg.sv
// axi4_stream_src_pkg: shared types and constants for the AXI4-Stream source.
//   state_t    : packet FSM state (IDLE, SEND)
//   LFSR_SEED  : reset value of the throttle LFSR
//   LFSR_TAPS  : Fibonacci tap mask for x^16+x^14+x^13+x^11+1
//   lfsr_next(): one left-shift step of the LFSR
package axi4_stream_src_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Taps at bits 15,13,12,10 feed the XOR; the result shifts in at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axi4_stream_src_if.sv
// axi4_stream_src_if: command + AXI4-Stream bundle for axi4_stream_src.
//   cmd_vld/cmd_rdy/cmd_len/cmd_dat/cmd_thr : packet command handshake
//   TVALID/TREADY/TDATA/TKEEP/TLAST         : AXI4-Stream master channel
//   master : the source side (consumes commands, drives the stream)
//   slave  : the environment side (issues commands, sinks the stream)
interface axi4_stream_src_if #(
  parameter int DW = 32,
  parameter int LW = 16
) ();
  localparam int BW = DW / 8;

  logic          cmd_vld;
  logic          cmd_rdy;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_dat;
  logic [7:0]    cmd_thr;

  logic          TVALID;
  logic          TREADY;
  logic [DW-1:0] TDATA;
  logic [BW-1:0] TKEEP;
  logic          TLAST;

  modport master (
    input  cmd_vld, cmd_len, cmd_dat, cmd_thr, TREADY,
    output cmd_rdy, TVALID, TDATA, TKEEP, TLAST
  );

  modport slave (
    output cmd_vld, cmd_len, cmd_dat, cmd_thr, TREADY,
    input  cmd_rdy, TVALID, TDATA, TKEEP, TLAST
  );
endinterface

// File: rtl/axi4_stream_lfsr.sv
// axi4_stream_lfsr: 16-bit Fibonacci LFSR used to throttle stream valid.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset, loads LFSR_SEED
//   i_en   : advance one step per cycle when high
//   o_lfsr : current LFSR state
module axi4_stream_lfsr
  import axi4_stream_src_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_lfsr <= LFSR_SEED;
    else if (i_en) r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/axi4_stream_src.sv
// axi4_stream_src: turns a (length, start value, throttle) command into one
// AXI4-Stream packet of incrementing beats with correct TKEEP/TLAST, with
// optional pseudo-random idle cycles between beats.
//   ACLK, ARESET : clock and asynchronous active-high reset
//   bus          : command + stream bundle (master modport)
//   busy         : a packet is in progress
//   pkt_cnt      : completed packets, wraps at 2^32
// Every output is a flop; TREADY and cmd_vld only reach next-state logic.
module axi4_stream_src
  import axi4_stream_src_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi4_stream_src_if.master        bus,
  output logic                     busy,
  output logic [31:0]              pkt_cnt
);
  localparam int BW = DW / 8;

  state_t        r_state;
  logic [LW-1:0] r_beat;      // index of the beat being presented / pending
  logic [LW-1:0] r_last_idx;  // N-1
  logic [LW-1:0] r_rem;       // len mod BW, bytes valid in the last beat
  logic [DW-1:0] r_dat;
  logic [7:0]    r_thr;

  logic          r_cmd_rdy, r_busy, r_tvalid, r_tlast;
  logic [DW-1:0] r_tdata;
  logic [BW-1:0] r_tkeep;
  logic [31:0]   r_pkt_cnt;

  logic [15:0]   w_lfsr;
  logic          w_unused;
  logic          w_beat_hs, w_thr_ok, w_is_last;
  logic [LW-1:0] w_beat_nxt;
  logic [BW-1:0] w_keep_last;

  axi4_stream_lfsr u_lfsr (
    .i_clk  (ACLK),
    .i_rst  (ARESET),
    .i_en   (1'b1),
    .o_lfsr (w_lfsr)
  );

  assign w_unused   = ^w_lfsr[15:8];
  assign w_thr_ok   = (w_lfsr[7:0] >= r_thr);
  assign w_beat_hs  = r_tvalid & bus.TREADY;
  // A handshake moves to the next beat so it can be presented back-to-back.
  assign w_beat_nxt = w_beat_hs ? r_beat + LW'(1) : r_beat;
  assign w_is_last  = (w_beat_nxt == r_last_idx);

  // Remainder 0 means the last beat is full.
  always_comb begin
    w_keep_last = '0;
    for (int i = 0; i < BW; i++)
      w_keep_last[i] = (r_rem == '0) || (LW'(i) < r_rem);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_last_idx <= '0;
      r_rem      <= '0;
      r_dat      <= '0;
      r_thr      <= '0;
      r_cmd_rdy  <= 1'b1;
      r_busy     <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // cmd_rdy is high throughout IDLE, so cmd_vld alone is the handshake.
          if (bus.cmd_vld) begin
            r_dat      <= bus.cmd_dat;
            r_thr      <= bus.cmd_thr;
            r_rem      <= bus.cmd_len % LW'(BW);
            r_last_idx <= (bus.cmd_len - LW'(1)) / LW'(BW);
            r_beat     <= '0;
            // Zero-length commands are consumed and dropped.
            if (bus.cmd_len != '0) begin
              r_state   <= SEND;
              r_cmd_rdy <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
        end
        SEND: begin
          if (w_beat_hs && r_tlast) begin
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            r_state   <= IDLE;
            r_cmd_rdy <= 1'b1;
            r_busy    <= 1'b0;
          end else if (!r_tvalid || w_beat_hs) begin
            // A pending beat is never touched; only an empty slot or a
            // just-accepted beat lets the throttle decide the next cycle.
            r_beat   <= w_beat_nxt;
            r_tvalid <= w_thr_ok;
            r_tdata  <= r_dat + DW'(w_beat_nxt);
            r_tkeep  <= w_is_last ? w_keep_last : '1;
            r_tlast  <= w_thr_ok & w_is_last;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy = r_cmd_rdy;
  assign bus.TVALID  = r_tvalid;
  assign bus.TDATA   = r_tdata;
  assign bus.TKEEP   = r_tkeep;
  assign bus.TLAST   = r_tlast;
  assign busy        = r_busy;
  assign pkt_cnt     = r_pkt_cnt;
endmodule

// File: tb/tb_axi4_stream_src.sv
// tb_axi4_stream_src: directed bench for axi4_stream_src (DW=32, LW=16).
// Expected beats are hand-computed; a monitor also checks that a stalled
// beat stays valid and stable until it is accepted.
module tb_axi4_stream_src;
  localparam int DW = 32;
  localparam int LW = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        busy;
  logic [31:0] pkt_cnt;

  logic rdy_dir, rnd_rdy, r_rand;
  int   n_chk = 0;
  int   n_err = 0;
  int   w;

  axi4_stream_src_if #(.DW(DW), .LW(LW)) bus ();

  axi4_stream_src #(.DW(DW), .LW(LW)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .bus     (bus),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  always #5 ACLK = ~ACLK;

  // Random ready changes mid-cycle so it is stable around both edges.
  initial r_rand = 1'b1;
  always @(posedge ACLK) if (rnd_rdy) begin #1 r_rand = 1'($urandom_range(0, 1)); end
  assign bus.TREADY = rnd_rdy ? r_rand : rdy_dir;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Stall monitor: a beat seen valid-but-not-ready must reappear unchanged.
  logic          p_stall = 1'b0;
  logic [DW-1:0] p_data;
  logic [3:0]    p_keep;
  logic          p_last;
  always @(negedge ACLK) begin
    if (ARESET) p_stall = 1'b0;
    else begin
      if (p_stall) begin
        chk("hold_vld",  bus.TVALID, 1'b1);
        chk("hold_data", bus.TDATA,  p_data);
        chk("hold_keep", bus.TKEEP,  p_keep);
        chk("hold_last", bus.TLAST,  p_last);
      end
      p_stall = bus.TVALID && !bus.TREADY;
      p_data  = bus.TDATA;
      p_keep  = bus.TKEEP;
      p_last  = bus.TLAST;
    end
  end

  task automatic send_cmd(input logic [LW-1:0] len, input logic [DW-1:0] dat, input logic [7:0] thr);
    @(negedge ACLK);
    bus.cmd_vld = 1'b1;
    bus.cmd_len = len;
    bus.cmd_dat = dat;
    bus.cmd_thr = thr;
    @(negedge ACLK);
    bus.cmd_vld = 1'b0;
  endtask

  // Waits (bounded) for a beat that will be accepted at the next edge.
  task automatic get_beat(input string tag, input logic [DW-1:0] edat, input logic [3:0] ekeep,
                          input logic elast, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge ACLK);
      waited++;
    end while (!(bus.TVALID && bus.TREADY) && waited < budget);
    chk({tag, "_hs"}, bus.TVALID && bus.TREADY, 1'b1);
    if (bus.TVALID && bus.TREADY) begin
      chk({tag, "_data"}, bus.TDATA, edat);
      chk({tag, "_keep"}, bus.TKEEP, ekeep);
      chk({tag, "_last"}, bus.TLAST, elast);
    end
  endtask

  initial begin
    bus.cmd_vld = 1'b0;
    bus.cmd_len = '0;
    bus.cmd_dat = '0;
    bus.cmd_thr = '0;
    rdy_dir = 1'b1;
    rnd_rdy = 1'b0;
    ARESET  = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("rst_rdy",  bus.cmd_rdy, 1'b1);
    chk("rst_vld",  bus.TVALID,  1'b0);
    chk("rst_data", bus.TDATA,   32'h0);
    chk("rst_keep", bus.TKEEP,   4'h0);
    chk("rst_last", bus.TLAST,   1'b0);
    chk("rst_busy", busy,        1'b0);
    chk("rst_cnt",  pkt_cnt,     32'h0);
    ARESET = 1'b0;

    // 10 bytes from 0x100: three beats, last one 2 bytes.
    send_cmd(16'd10, 32'h100, 8'd0);
    chk("t1_busy",   busy,        1'b1);
    chk("t1_rdy",    bus.cmd_rdy, 1'b0);
    chk("t1_vld_e1", bus.TVALID,  1'b0);
    get_beat("t1b0", 32'h100, 4'hF, 1'b0, 10, w); chk("t1b0_lat", w, 1);
    get_beat("t1b1", 32'h101, 4'hF, 1'b0, 10, w); chk("t1b1_gap", w, 1);
    get_beat("t1b2", 32'h102, 4'h3, 1'b1, 10, w); chk("t1b2_gap", w, 1);
    @(negedge ACLK);
    chk("t1_end_vld",  bus.TVALID,  1'b0);
    chk("t1_end_last", bus.TLAST,   1'b0);
    chk("t1_end_rdy",  bus.cmd_rdy, 1'b1);
    chk("t1_end_busy", busy,        1'b0);
    chk("t1_cnt",      pkt_cnt,     32'd1);

    // Data wraps past 2^32.
    send_cmd(16'd8, 32'hFFFF_FFFF, 8'd0);
    get_beat("t2b0", 32'hFFFF_FFFF, 4'hF, 1'b0, 10, w);
    get_beat("t2b1", 32'h0,         4'hF, 1'b1, 10, w);
    @(negedge ACLK);
    chk("t2_cnt", pkt_cnt, 32'd2);

    // Zero-length command is dropped.
    send_cmd(16'd0, 32'h55, 8'd0);
    chk("t3_rdy",  bus.cmd_rdy, 1'b1);
    chk("t3_busy", busy,        1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t3_vld", bus.TVALID, 1'b0);
    end
    chk("t3_cnt", pkt_cnt, 32'd2);

    // 4-beat packet, beat 2 stalled for 5 cycles.
    send_cmd(16'd16, 32'h200, 8'd0);
    get_beat("t4b0", 32'h200, 4'hF, 1'b0, 10, w);
    @(posedge ACLK); #1 rdy_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t4_st_vld",  bus.TVALID, 1'b1);
      chk("t4_st_data", bus.TDATA,  32'h201);
      chk("t4_st_keep", bus.TKEEP,  4'hF);
      chk("t4_st_last", bus.TLAST,  1'b0);
    end
    @(posedge ACLK); #1 rdy_dir = 1'b1;
    get_beat("t4b1", 32'h201, 4'hF, 1'b0, 10, w);
    get_beat("t4b2", 32'h202, 4'hF, 1'b0, 10, w);
    get_beat("t4b3", 32'h203, 4'hF, 1'b1, 10, w);
    @(negedge ACLK);
    chk("t4_cnt", pkt_cnt, 32'd3);

    // Heavy throttle with random ready; 13 bytes -> last beat keeps 1 byte.
    rnd_rdy = 1'b1;
    send_cmd(16'd13, 32'h300, 8'hFF);
    get_beat("t5b0", 32'h300, 4'hF, 1'b0, 20000, w);
    get_beat("t5b1", 32'h301, 4'hF, 1'b0, 20000, w);
    get_beat("t5b2", 32'h302, 4'hF, 1'b0, 20000, w);
    get_beat("t5b3", 32'h303, 4'h1, 1'b1, 20000, w);
    rnd_rdy = 1'b0;
    @(negedge ACLK);
    chk("t5_cnt", pkt_cnt,    32'd4);
    chk("t5_vld", bus.TVALID, 1'b0);

    // Reset in the middle of a 5-beat packet.
    send_cmd(16'd20, 32'h400, 8'd0);
    get_beat("t6b0", 32'h400, 4'hF, 1'b0, 10, w);
    @(negedge ACLK);
    chk("t6_pre_vld", bus.TVALID, 1'b1);
    ARESET = 1'b1;
    #1;
    chk("t6_vld",  bus.TVALID,  1'b0);
    chk("t6_last", bus.TLAST,   1'b0);
    chk("t6_cnt",  pkt_cnt,     32'd0);
    chk("t6_rdy",  bus.cmd_rdy, 1'b1);
    chk("t6_busy", busy,        1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
    send_cmd(16'd1, 32'h55, 8'd0);
    get_beat("t7b0", 32'h55, 4'h1, 1'b1, 10, w); chk("t7b0_lat", w, 1);
    @(negedge ACLK);
    chk("t7_cnt", pkt_cnt,     32'd1);
    chk("t7_rdy", bus.cmd_rdy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_stream_src.md
# axi4_stream_src

Synthesizable AXI4-Stream source (transmitter) that turns a simple command (byte length, start value, throttle level) into one packet of incrementing data beats. It terminates TLAST and TKEEP correctly and inserts optional pseudo-random idle cycles. It is the driving end for stream drains and slave VIPs in the testbenches, and it also serves as on-chip traffic generator.

## Interface
- DW, 32: TDATA width in bits; multiple of 8, ≥ 8; BW = DW/8 bytes per beat
- LW, 16: width of the byte-length field
- ACLK  in  1  clock; all logic rising-edge
- ARESET  in  1  asynchronous, active-high reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; high only in IDLE
- cmd_len  in  LW  packet length in bytes
- cmd_dat  in  DW  TDATA value of first beat
- cmd_thr  in  8  throttle level; 0 = never idle
- TVALID  out  1  stream valid
- TREADY  in  1  stream ready from sink
- TDATA  out  DW  stream data
- TKEEP  out  BW  byte qualifiers
- TLAST  out  1  last beat of packet
- busy  out  1  packet in progress (state SEND)
- pkt_cnt  out  32  packets completed, wraps at 2^32

## Operation
- FSM states: IDLE, SEND.
- IDLE: cmd_rdy=1. A handshake (cmd_vld & cmd_rdy) latches len, dat and thr.
  - If cmd_len=0, the command is consumed and dropped. State stays IDLE, no beats are sent, pkt_cnt is unchanged.
  - Otherwise the next state is SEND.
- Beat count N = ceil(cmd_len/BW). Beat k (0..N-1) carries TDATA = dat + k, mod 2^DW.
- TKEEP = all ones on every beat except the last one.
  - Last beat: the low (cmd_len mod BW) bits set, or all ones if the remainder is 0.
  - TLAST=1 only on beat N-1.
- Throttle: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances every cycle regardless of state.
  - In SEND, while TVALID=0, TVALID is set in the next cycle iff lfsr[7:0] ≥ thr.
  - thr=0 gives back-to-back valid.
- AXI rule: once TVALID=1, TVALID, TDATA, TKEEP and TLAST are held stable until TREADY=1. Throttle never drops a pending beat.
- On handshake of a non-last beat: the beat index increments, and the next beat follows under the same throttle rule (eligible in the very next cycle).
- On handshake of the last beat:
  - TVALID→0, TLAST→0
  - pkt_cnt+1
  - state→IDLE, so cmd_rdy=1 in the next cycle.
- cmd_* inputs are ignored outside IDLE.

## Timing
- All outputs are registered. Nothing is combinational from TREADY or cmd_vld to any output.
- Reset values: cmd_rdy=1, TVALID=0, TDATA=0, TKEEP=0, TLAST=0, busy=0, pkt_cnt=0, LFSR=seed, state=IDLE.
- Command accepted at edge E: busy=1 and cmd_rdy=0 after E. The earliest TVALID=1 is in the cycle after E+1 (thr=0).
- With thr=0 and TREADY held high, a packet takes N cycles of TVALID, followed by 1 cycle in IDLE before the next command can be accepted.
- Packet-to-packet minimum gap is 1 cycle of TVALID=0 (the IDLE cycle), plus 1 cycle for command acceptance.
- Reset asserted mid-packet: all state clears immediately and asynchronously. TVALID falls without a handshake, which AXI allows during reset. The partial packet is lost and is not counted.
- TREADY=0 for an arbitrary duration: the outputs stay frozen and the LFSR keeps running.

## Structure
- Package axi4_stream_src_pkg holds:
  - state enum (IDLE, SEND)
  - LFSR seed constant 16'hACE1
  - tap mask constant 16'hB400
- Sub-module axi4_stream_lfsr: 16-bit LFSR with enable and asynchronous active-high reset. It is reused by future sink-side throttling.
- Remaining datapath: beat counter (LW bits), remainder-to-TKEEP decode, data adder. All live in the top module.

## Test plan
- DW=32, thr=0, TREADY=1, cmd_len=10, cmd_dat=32'h100:
  - 3 beats: TDATA 100, 101, 102
  - TKEEP F, F, 3
  - TLAST on beat 3 only
  - pkt_cnt=1
- cmd_len=8, cmd_dat=32'hFFFF_FFFF:
  - TDATA FFFFFFFF then 0 (wrap)
  - TKEEP F on both beats
- cmd_len=0: cmd_rdy stays 1, no TVALID, pkt_cnt unchanged.
- TREADY held low 5 cycles on beat 2 of a 4-beat packet: outputs stable for all 5 cycles, then the packet completes in order.
- thr=8'hFF, 4-beat packet: the beats still complete, and idle gaps appear only when TVALID=0. An assertion flags any TVALID drop without a handshake.
- ARESET asserted on beat 2 of a 5-beat packet: TVALID=0 immediately, pkt_cnt=0, cmd_rdy=1. A new 1-byte command then yields one beat with TKEEP=1 and TLAST=1.
